// File: rtl/dopcode_decoder.sv
// -----------------------------------------------------------------------------
// dopcode_decoder
// Purpose:
//   Bit-serial converter from a W-bit two's-complement word to W-bit
//   sign-magnitude form. One bit is processed per clock, LSB first. A negative
//   word is negated with the copy-through-first-1-then-invert rule, so no adder
//   is needed. The most negative input has no representable magnitude and
//   saturates to sign=1 with an all-ones magnitude.
//
// Parameters:
//   W            data width including the sign bit (4..32)
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   producer has a word on in_data_i
//   in_ready_o   block can accept a word (high only while idle)
//   in_data_i    two's-complement operand
//   out_valid_o  out_data_o holds a result
//   out_ready_i  consumer takes out_data_o
//   out_data_o   sign-magnitude result, [W-1]=sign, [W-2:0]=magnitude
//   busy_o       high while a word is being shifted or waiting to be taken
//   out_ovf_o    (only with DOPDEC_OVF_FLAG_EN) result was saturated
//
// Configuration:
//   DOPDEC_OVF_FLAG_EN  when defined, adds the out_ovf_o flag. Saturation and
//                       timing are identical either way.
// -----------------------------------------------------------------------------
module dopcode_decoder #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         busy_o
`ifdef DOPDEC_OVF_FLAG_EN
    ,
    output logic         out_ovf_o
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    sr_q;
    logic [W-2:0]    mag_q;
    logic            sign_q;
    logic            seen1_q;
    logic            sat_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [W-1:0]    out_data_q;
`ifdef DOPDEC_OVF_FLAG_EN
    logic            out_ovf_q;
`endif

    logic            magBit_d;
    logic            seen1_d;
    logic [W-2:0]    mag_d;

    // Per-step magnitude bit. For a negative word every bit up to and
    // including the first 1 passes unchanged; every later bit is inverted.
    always_comb begin
        magBit_d = sr_q[0];
        seen1_d  = seen1_q;
        if (sign_q) begin
            magBit_d = seen1_q ? ~sr_q[0] : sr_q[0];
            seen1_d  = seen1_q | sr_q[0];
        end
        mag_d = {magBit_d, mag_q[W-2:1]};
    end

    // Control FSM and datapath. The magnitude register collects the first
    // W-1 bits; the final step sees the sign position, whose converted bit is
    // not part of the magnitude, so that step only publishes the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            seen1_q     <= 1'b0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
`ifdef DOPDEC_OVF_FLAG_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= SHIFT;
                        sr_q       <= in_data_i;
                        mag_q      <= '0;
                        sign_q     <= in_data_i[W-1];
                        seen1_q    <= 1'b0;
                        sat_q      <= in_data_i[W-1] && (in_data_i[W-2:0] == '0);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_q    <= {1'b0, sr_q[W-1:1]};
                    seen1_q <= seen1_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W-1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sat_q ? '1 : {sign_q, mag_q};
`ifdef DOPDEC_OVF_FLAG_EN
                        out_ovf_q   <= sat_q;
`endif
                    end else begin
                        mag_q <= mag_d;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_data_q  <= '0;
`ifdef DOPDEC_OVF_FLAG_EN
                        out_ovf_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
`ifdef DOPDEC_OVF_FLAG_EN
    assign out_ovf_o   = out_ovf_q;
`endif

endmodule

// File: tb/tb_dopcode_decoder.sv
// -----------------------------------------------------------------------------
// tb_dopcode_decoder
// Purpose:
//   Self-checking bench for dopcode_decoder at W=16. Directed boundary words,
//   backpressure, reset in mid-conversion, then a randomized sweep compared
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_dopcode_decoder;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inData;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;
    logic         busy;
`ifdef DOPDEC_OVF_FLAG_EN
    logic         outOvf;
`endif

    int checkCount = 0;
    int passCount  = 0;

    dopcode_decoder #(.W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_data_i   (inData),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData),
        .busy_o      (busy)
`ifdef DOPDEC_OVF_FLAG_EN
        ,
        .out_ovf_o   (outOvf)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion from plain signed arithmetic: |x| with the sign
    // kept separately; the most negative value saturates.
    function automatic logic [W-1:0] refModel(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
        if (v == -(1 << (W-1)))
            return '1;
        if (v < 0)
            return {1'b1, (W-1)'(-v)};
        return {1'b0, (W-1)'(v)};
    endfunction

    function automatic logic refOvf(input logic [W-1:0] x);
        return int'($signed(x)) == -(1 << (W-1));
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Sends one word, checks latency, result, flag and backpressure stability,
    // then consumes it and checks the return to idle.
    task automatic applyStimulus(input logic [W-1:0] data, input int holdCycles,
                                 input bit noisyInput);
        int n;
        logic [W-1:0] expData;
        expData  = refModel(data);
        outReady = 1'b0;
        @(negedge clk);
        inData  = data;
        inValid = 1'b1;
        n = 0;
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            checkOutput("inReadyWait", 32'(inReady), 32'd1);
            inValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (noisyInput) begin
            inValid = 1'($urandom_range(0, 1));
            inData  = W'($urandom);
        end else begin
            inValid = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!outValid && n < W + 6);
        inValid = 1'b0;
        checkOutput("latency", 32'(n), 32'(W));
        checkOutput("outData", 32'(outData), 32'(expData));
        checkOutput("busyDone", 32'(busy), 32'd1);
        checkOutput("inReadyDone", 32'(inReady), 32'd0);
`ifdef DOPDEC_OVF_FLAG_EN
        checkOutput("outOvf", 32'(outOvf), 32'(refOvf(data)));
`endif
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(outValid), 32'd1);
            checkOutput("holdData", 32'(outData), 32'(expData));
            checkOutput("holdInReady", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("idleValid", 32'(outValid), 32'd0);
        checkOutput("idleInReady", 32'(inReady), 32'd1);
        checkOutput("idleBusy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] corners [6];
        corners = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h8001};

        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstOutData", 32'(outData), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
`ifdef DOPDEC_OVF_FLAG_EN
        checkOutput("rstOvf", 32'(outOvf), 32'd0);
`endif
        rst = 1'b0;

        // Directed words, including the boundary values
        applyStimulus(16'h0005, 0, 1'b0);
        applyStimulus(16'hFFFB, 0, 1'b0);
        applyStimulus(16'hFFFF, 0, 1'b0);
        applyStimulus(16'h0000, 0, 1'b0);
        applyStimulus(16'h8000, 0, 1'b0);
        applyStimulus(16'h7FFF, 0, 1'b0);
        applyStimulus(16'hFFFB, 10, 1'b0);

        // Reset in the middle of a conversion discards the word
        @(negedge clk);
        inData  = 16'h1234;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstInReady", 32'(inReady), 32'd1);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstOutData", 32'(outData), 32'd0);
        repeat (W + 2) @(negedge clk);
        checkOutput("midRstNoValid", 32'(outValid), 32'd0);
        applyStimulus(16'hFFFE, 0, 1'b0);

        // Randomized sweep with boundary words mixed in and noisy in_valid
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
                word = corners[$urandom_range(0, 5)];
            else
                word = W'($urandom);
            applyStimulus(word, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
